// File: rtl/rtc_pkg.sv
// rtc_pkg: shared mode encoding, field limits and display helpers for the HH:MM:SS clock.
// Latency: pure types and combinational functions, no state.
// Backpressure: not applicable.
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Segments a..g on bits 0..6, active-high; anything above 9 shows nothing.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Split 0..59 into {tens, ones} with a compare chain so no divider is built.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] base;
    if (v >= 6'd50) begin
      tens = 4'd5; base = 6'd50;
    end else if (v >= 6'd40) begin
      tens = 4'd4; base = 6'd40;
    end else if (v >= 6'd30) begin
      tens = 4'd3; base = 6'd30;
    end else if (v >= 6'd20) begin
      tens = 4'd2; base = 6'd20;
    end else if (v >= 6'd10) begin
      tens = 4'd1; base = 6'd10;
    end else begin
      tens = 4'd0; base = 6'd0;
    end
    return {tens, 4'(v - base)};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser plus stability counter for one raw active-high key.
// Latency: level changes DEBOUNCE_CYCLES+2 cycles after a stable raw change; press pulses with that change.
// Backpressure: none; press is a one-cycle pulse and never repeats while the key is held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          armed_q;
  logic          press_q;

  // Synchroniser keeps following the pin through reset so a key held across
  // reset is seen as already down once reset drops.
  always_ff @(posedge clk) begin
    sync1_q <= raw;
    sync2_q <= sync1_q;
  end

  // Stability counter, debounced level and press pulse; presses are only
  // armed once the key has been seen released after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (!level_q && !sync2_q) begin
        armed_q <= 1'b1;
      end
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          press_q <= sync2_q & armed_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/rtc_hms_core.sv
// rtc_hms_core: HH:MM:SS clock with a two-key time-set FSM and a multiplexed HH:MM 7-seg driver.
// Latency: time moves on the tick edge; a key acts DEBOUNCE_CYCLES+3 cycles after its raw edge; seg/dig_n lag the scan index by one cycle.
// Backpressure: none; keys are sampled every cycle and the display scans freely.
module rtc_hms_core
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 65536,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int SCAN_DIV        = 256,
  parameter int BLINK_SECS_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_add,
  output logic [6:0] seg,
  output logic [3:0] dig_n,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  localparam int BLINK_PERIOD = (TICKS_PER_SEC / BLINK_SECS_DIV > 0) ?
                                (TICKS_PER_SEC / BLINK_SECS_DIV) : 1;
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX);
  localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);

  logic          mode_press;
  logic          add_press;
  // Debounced levels are not needed by the clock logic, only the press pulses.
  logic [1:0]    unused_levels;

  mode_e         mode_q;
  logic [PW-1:0] presc_q;
  logic [5:0]    seconds_q;
  logic [5:0]    minutes_q;
  logic [4:0]    hours_q;
  logic          sec_tick_q;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  logic [SW-1:0] scan_cnt_q;
  logic [1:0]    idx_q;
  logic          live_q;

  logic [7:0]    hour_bcd;
  logic [7:0]    min_bcd;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_d;
  logic [3:0]    dig_n_d;
  logic [6:0]    seg_q;
  logic [3:0]    dig_n_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (key_mode),
    .level (unused_levels[0]),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_add (
    .clk   (clk),
    .reset (reset),
    .raw   (key_add),
    .level (unused_levels[1]),
    .press (add_press)
  );

  // Prescaler, time counters and set-mode FSM share one block because leaving
  // SET_MIN must clear seconds and the prescaler on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= RUN;
      presc_q    <= '0;
      seconds_q  <= '0;
      minutes_q  <= '0;
      hours_q    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      if (mode_q == RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_q    <= '0;
          sec_tick_q <= 1'b1;
          if (seconds_q == SEC_LAST) begin
            seconds_q <= '0;
            if (minutes_q == MIN_LAST) begin
              minutes_q <= '0;
              hours_q   <= (hours_q == HOUR_LAST) ? 5'd0 : hours_q + 5'd1;
            end else begin
              minutes_q <= minutes_q + 6'd1;
            end
          end else begin
            seconds_q <= seconds_q + 6'd1;
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      // A mode press wins over a simultaneous add press.
      case (mode_q)
        RUN: begin
          if (mode_press) mode_q <= SET_HOUR;
        end
        SET_HOUR: begin
          if (mode_press) begin
            mode_q <= SET_MIN;
          end else if (add_press) begin
            hours_q <= (hours_q == HOUR_LAST) ? 5'd0 : hours_q + 5'd1;
          end
        end
        SET_MIN: begin
          if (mode_press) begin
            mode_q    <= RUN;
            seconds_q <= '0;
            presc_q   <= '0;
          end else if (add_press) begin
            minutes_q <= (minutes_q == MIN_LAST) ? 6'd0 : minutes_q + 6'd1;
          end
        end
        default: mode_q <= RUN;
      endcase
    end
  end

  // Free-running blink phase used to flash the field being edited.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Digit scan: index walks 3->2->1->0 every SCAN_DIV cycles; display goes
  // live on the first step so no strobe is driven straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd3;
      live_q     <= 1'b0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q - 2'd1;
      live_q     <= 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SW'(1);
    end
  end

  assign hour_bcd = bin_to_bcd({1'b0, hours_q});
  assign min_bcd  = bin_to_bcd(minutes_q);

  // Pick the BCD digit for the current scan position.
  always_comb begin
    digit = min_bcd[3:0];
    case (idx_q)
      2'd3:    digit = hour_bcd[7:4];
      2'd2:    digit = hour_bcd[3:0];
      2'd1:    digit = min_bcd[7:4];
      default: digit = min_bcd[3:0];
    endcase
  end

  assign blank = blink_q && (((mode_q == SET_HOUR) &&  idx_q[1]) ||
                             ((mode_q == SET_MIN)  && !idx_q[1]));

  // Next display word: blanked segments for the field being edited, strobe unchanged.
  always_comb begin
    seg_d   = blank ? 7'h00 : seg7_decode(digit);
    dig_n_d = ~(4'b0001 << idx_q);
  end

  // Registered segment/strobe outputs, held dark until the scan is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= 7'h00;
      dig_n_q <= 4'hF;
    end else if (live_q) begin
      seg_q   <= seg_d;
      dig_n_q <= dig_n_d;
    end
  end

  assign seg      = seg_q;
  assign dig_n    = dig_n_q;
  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign mode     = mode_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_rtc_hms_core.sv
// tb_rtc_hms_core: scenario tasks for the HH:MM:SS clock with a small expected-value queue.
// Latency: samples on the falling edge, drives on the falling edge.
// Backpressure: not applicable.
module tb_rtc_hms_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_add = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_n;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       sec_tick;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] dig_n;
    logic [6:0] seg;
  } disp_t;

  logic [7:0] exp_q[$];
  disp_t      disp_q[$];
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  rtc_hms_core #(
    .TICKS_PER_SEC   (4),
    .DEBOUNCE_CYCLES (2),
    .SCAN_DIV        (2),
    .BLINK_SECS_DIV  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_mode (key_mode),
    .key_add  (key_add),
    .seg      (seg),
    .dig_n    (dig_n),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .sec_tick (sec_tick)
  );

  task automatic do_reset();
    reset = 1'b1; key_mode = 1'b0; key_add = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tap(input logic m, input logic a, input int hold);
    key_mode = m; key_add = a;
    repeat (hold) @(negedge clk);
    key_mode = 1'b0; key_add = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // From RUN: enter SET_HOUR, add h times, enter SET_MIN, add m times.
  task automatic set_time(input int h, input int m);
    tap(1'b1, 1'b0, 3);
    repeat (h) tap(1'b0, 1'b1, 3);
    tap(1'b1, 1'b0, 3);
    repeat (m) tap(1'b0, 1'b1, 3);
  endtask

  task automatic test_reset();
    reset = 1'b1; key_mode = 1'b0; key_add = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (hours !== 5'd0) begin bad++; $display("FAIL reset_hours got=%0d want=0", hours); end
    total++; if (minutes !== 6'd0) begin bad++; $display("FAIL reset_minutes got=%0d want=0", minutes); end
    total++; if (seconds !== 6'd0) begin bad++; $display("FAIL reset_seconds got=%0d want=0", seconds); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", sec_tick); end
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL reset_seg got=%h want=00", seg); end
    total++; if (dig_n !== 4'hF) begin bad++; $display("FAIL reset_dig_n got=%b want=1111", dig_n); end
    reset = 1'b0;
  endtask

  task automatic test_count_minute();
    int ticks;
    int wide;
    logic prev;
    ticks = 0; wide = 0; prev = 1'b0;
    do_reset();
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) begin
        ticks++;
        if (prev === 1'b1) wide++;
      end
      prev = sec_tick;
    end
    total++; if (ticks != 60) begin bad++; $display("FAIL minute_ticks got=%0d want=60", ticks); end
    total++; if (wide != 0) begin bad++; $display("FAIL minute_tick_width got=%0d want=0", wide); end
    total++; if (minutes !== 6'd1) begin bad++; $display("FAIL minute_minutes got=%0d want=1", minutes); end
    total++; if (seconds !== 6'd0) begin bad++; $display("FAIL minute_seconds got=%0d want=0", seconds); end
    total++; if (hours !== 5'd0) begin bad++; $display("FAIL minute_hours got=%0d want=0", hours); end
  endtask

  task automatic test_wrap();
    int n;
    int k;
    do_reset();
    set_time(23, 59);
    tap(1'b1, 1'b0, 3);
    n = 0;
    while (seconds !== 6'd59 && n < 300) begin @(negedge clk); n++; end
    total++; if (n >= 300) begin bad++; $display("FAIL wrap_wait got=%0d want<300", n); end
    total++; if (hours !== 5'd23 || minutes !== 6'd59) begin
      bad++; $display("FAIL wrap_pre got=%0d:%0d want=23:59", hours, minutes);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (sec_tick !== 1'b1 && k < 10);
    total++; if (k != 4) begin bad++; $display("FAIL wrap_tick_delay got=%0d want=4", k); end
    total++; if ({hours, minutes, seconds} !== 17'd0) begin
      bad++; $display("FAIL wrap_value got=%0d:%0d:%0d want=0:0:0", hours, minutes, seconds);
    end
  endtask

  task automatic test_set_fields();
    logic [7:0] e;
    int n;
    int k;
    do_reset();
    exp_q.push_back(8'd1);
    tap(1'b1, 1'b0, 3);
    e = exp_q.pop_front();
    total++; if ({6'd0, mode} !== e) begin bad++; $display("FAIL set_enter_hour got=%0d want=%0d", mode, e); end
    exp_q.push_back(8'd1);
    repeat (25) tap(1'b0, 1'b1, 3);
    e = exp_q.pop_front();
    total++; if ({3'd0, hours} !== e) begin bad++; $display("FAIL set_hours got=%0d want=%0d", hours, e); end
    exp_q.push_back(8'd2);
    tap(1'b1, 1'b0, 3);
    e = exp_q.pop_front();
    total++; if ({6'd0, mode} !== e) begin bad++; $display("FAIL set_enter_min got=%0d want=%0d", mode, e); end
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd1);
    repeat (61) tap(1'b0, 1'b1, 3);
    e = exp_q.pop_front();
    total++; if ({2'd0, minutes} !== e) begin bad++; $display("FAIL set_minutes got=%0d want=%0d", minutes, e); end
    e = exp_q.pop_front();
    total++; if ({3'd0, hours} !== e) begin bad++; $display("FAIL set_no_carry got=%0d want=%0d", hours, e); end
    key_mode = 1'b1;
    n = 0;
    while (mode !== 2'd0 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL set_exit_wait got=%0d want<20", n); end
    total++; if (seconds !== 6'd0) begin bad++; $display("FAIL set_exit_seconds got=%0d want=0", seconds); end
    k = 0;
    do begin @(negedge clk); k++; end while (sec_tick !== 1'b1 && k < 10);
    total++; if (k != 4) begin bad++; $display("FAIL set_first_tick got=%0d want=4", k); end
    key_mode = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL set_hold_repeat got=%0d want=0", mode); end
  endtask

  task automatic test_keys();
    do_reset();
    tap(1'b1, 1'b0, 1);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL key_glitch got=%0d want=0", mode); end
    tap(1'b1, 1'b0, 10);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL key_held_once got=%0d want=1", mode); end
    tap(1'b0, 1'b1, 1);
    total++; if (hours !== 5'd0) begin bad++; $display("FAIL key_add_glitch got=%0d want=0", hours); end
    tap(1'b1, 1'b1, 3);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL key_both_mode got=%0d want=2", mode); end
    total++; if (hours !== 5'd0) begin bad++; $display("FAIL key_both_add got=%0d want=0", hours); end
  endtask

  task automatic test_display();
    disp_t d;
    logic [3:0] prev;
    logic [3:0] dv;
    int n;
    int pos;
    int errs;
    int blanks;
    int lits;
    do_reset();
    set_time(12, 34);
    tap(1'b1, 1'b0, 3);
    disp_q.push_back('{dig_n: 4'b0111, seg: seg_tab[1]});
    disp_q.push_back('{dig_n: 4'b1011, seg: seg_tab[2]});
    disp_q.push_back('{dig_n: 4'b1101, seg: seg_tab[3]});
    disp_q.push_back('{dig_n: 4'b1110, seg: seg_tab[4]});
    n = 0;
    while (dig_n !== 4'b0111 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL disp_wait got=%b want=0111", dig_n); end
    for (int i = 0; i < 4; i++) begin
      d = disp_q.pop_front();
      total++; if (dig_n !== d.dig_n || seg !== d.seg) begin
        bad++; $display("FAIL disp_digit%0d got=%b/%h want=%b/%h", i, dig_n, seg, d.dig_n, d.seg);
      end
      prev = dig_n;
      n = 0;
      while (dig_n === prev && n < 10) begin @(negedge clk); n++; end
    end
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if ($countones(~dig_n) != 1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL disp_onehot got=%0d want=0", errs); end
    tap(1'b1, 1'b0, 3);
    tap(1'b1, 1'b0, 3);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL disp_setmin got=%0d want=2", mode); end
    errs = 0; blanks = 0; lits = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      case (dig_n)
        4'b0111: begin pos = 3; dv = 4'd1; end
        4'b1011: begin pos = 2; dv = 4'd2; end
        4'b1101: begin pos = 1; dv = 4'd3; end
        4'b1110: begin pos = 0; dv = 4'd4; end
        default: begin pos = -1; dv = 4'd0; end
      endcase
      if (pos < 0) errs++;
      else if (pos >= 2) begin
        if (seg !== seg_tab[dv]) errs++;
      end else if (seg === 7'h00) blanks++;
      else if (seg === seg_tab[dv]) lits++;
      else errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL blink_wrong got=%0d want=0", errs); end
    total++; if (blanks == 0) begin bad++; $display("FAIL blink_blank got=%0d want>0", blanks); end
    total++; if (lits == 0) begin bad++; $display("FAIL blink_lit got=%0d want>0", lits); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tap(1'b1, 1'b0, 3);
    repeat (3) tap(1'b0, 1'b1, 3);
    total++; if (hours !== 5'd3 || mode !== 2'd1) begin
      bad++; $display("FAIL mid_setup got=%0d/%0d want=3/1", hours, mode);
    end
    key_mode = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if ({hours, minutes, seconds} !== 17'd0) begin
      bad++; $display("FAIL mid_time got=%0d:%0d:%0d want=0:0:0", hours, minutes, seconds);
    end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL mid_mode got=%0d want=0", mode); end
    repeat (12) @(negedge clk);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL mid_held_event got=%0d want=0", mode); end
    key_mode = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL mid_release_event got=%0d want=0", mode); end
    tap(1'b1, 1'b0, 3);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL mid_repress got=%0d want=1", mode); end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    test_reset();
    test_count_minute();
    test_wrap();
    test_set_fields();
    test_keys();
    test_display();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
